des_key_scheduler: RTL and testbench

- Sequential DES key-schedule engine that generates all 16 round subkeys from the PC-1-permuted key halves C0/D0.
- Emits one subkey per accepted beat over a valid/ready interface.
- Generalises the per-round rotation stage:
  - parametrised half width and shift schedule;
  - encrypt (left-rotate) and decrypt (right-rotate, reverse-order) modes;
  - backpressure;
  - optional built-in PC-2 compression.
- Sits between key load logic and the Feistel round datapath.

---
 rtl/des_key_scheduler.sv | 170 +++++++++++++++++
 tb/tb_des_key_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_scheduler.sv
// des_key_scheduler
//   Sequential DES key-schedule engine. Takes the PC-1-permuted key halves
//   C0/D0 and produces the 16 round subkeys, one per accepted valid/ready beat.
//   Encrypt mode left-rotates per SHIFT_SCHED; decrypt mode emits the same keys
//   in reverse order by right-rotating.
//
//   Optional feature macro: DES_KS_PC2_EN
//     defined   : subkey_o[47:0] = PC-2({C,D}) in FIPS 46-3 bit order,
//                 subkey_o[55:48] = 0 (HALF_W must be 28).
//     undefined : subkey_o = {C,D}.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start_i       load request, accepted only while busy_o = 0
//   decrypt_i     mode sampled with start_i (1 = decrypt)
//   c0_i, d0_i    initial C/D halves
//   busy_o        high from accepted start until the last subkey handshake
//   key_valid_o   subkey_o/round_o valid
//   key_ready_i   consumer accepts current subkey
//   round_o       round index 0..15 of the current subkey
//   subkey_o      current round key
//   done_o        one-cycle pulse after the round-15 handshake
module des_key_scheduler #(
    parameter int unsigned HALF_W      = 28,
    parameter logic [15:0] SHIFT_SCHED = 16'h8103
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  decrypt_i,
    input  logic [HALF_W-1:0]     c0_i,
    input  logic [HALF_W-1:0]     d0_i,
    output logic                  busy_o,
    output logic                  key_valid_o,
    input  logic                  key_ready_i,
    output logic [3:0]            round_o,
    output logic [2*HALF_W-1:0]   subkey_o,
    output logic                  done_o
);

    generate
        if (HALF_W < 3) begin : g_bad_half_w
            $error("des_key_scheduler: HALF_W must be >= 3");
        end
    endgenerate

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [HALF_W-1:0] c_q, c_d, d_q, d_d;
    logic [3:0]        round_q, round_d;
    logic              mode_q, mode_d;
    logic              done_q, done_d;

    // by1 = 1 rotates by one position, otherwise by two.
    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic by1);
        return by1 ? {x[HALF_W-2:0], x[HALF_W-1]}
                   : {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
    endfunction

    function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic by1);
        return by1 ? {x[0], x[HALF_W-1:1]}
                   : {x[1:0], x[HALF_W-1:2]};
    endfunction

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    mode_d  = decrypt_i;
                    round_d = '0;
                    // Encrypt applies round 1's rotation at load; decrypt
                    // round 1 is the fully rotated key, i.e. C0/D0 itself.
                    if (decrypt_i) begin
                        c_d = c0_i;
                        d_d = d0_i;
                    end else begin
                        c_d = rotl(c0_i, SHIFT_SCHED[0]);
                        d_d = rotl(d0_i, SHIFT_SCHED[0]);
                    end
                end
            end
            S_RUN: begin
                if (key_ready_i) begin
                    if (round_q == 4'd15) begin
                        state_d = S_IDLE;
                        round_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        round_d = round_q + 4'd1;
                        // Next encrypt round r = round_q+2 uses bit r-1;
                        // next decrypt round r undoes encrypt round 18-r, bit 17-r.
                        if (mode_q) begin
                            c_d = rotr(c_q, SHIFT_SCHED[4'd15 - round_q]);
                            d_d = rotr(d_q, SHIFT_SCHED[4'd15 - round_q]);
                        end else begin
                            c_d = rotl(c_q, SHIFT_SCHED[round_q + 4'd1]);
                            d_d = rotl(d_q, SHIFT_SCHED[round_q + 4'd1]);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign busy_o      = (state_q == S_RUN);
    assign key_valid_o = (state_q == S_RUN);
    assign round_o     = round_q;
    assign done_o      = done_q;

`ifdef DES_KS_PC2_EN
    generate
        if (HALF_W != 28) begin : g_bad_pc2_width
            $error("des_key_scheduler: DES_KS_PC2_EN requires HALF_W == 28");
        end
    endgenerate

    // FIPS 46-3 PC-2: entry i is the 1-based source bit (bit 1 = MSB of {C,D})
    // of output bit i+1 (bit 1 = MSB of the 48-bit subkey).
    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    logic [2*HALF_W-1:0] cd;
    logic [47:0]         pc2_key;

    assign cd = {c_q, d_q};

    always_comb begin
        pc2_key = '0;
        for (int unsigned i = 0; i < 48; i++) begin
            pc2_key[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
        end
    end

    assign subkey_o = {8'h00, pc2_key};
`else
    assign subkey_o = {c_q, d_q};
`endif

endmodule

// File: tb/tb_des_key_scheduler.sv
// tb_des_key_scheduler
//   Directed self-checking bench for des_key_scheduler (HALF_W = 28, default
//   schedule). Expected subkeys come from the cumulative left-rotation per
//   encrypt round of the default schedule; decrypt round k equals encrypt
//   round 15-k. Builds with or without DES_KS_PC2_EN.
module tb_des_key_scheduler;

    localparam logic [27:0] C0 = 28'hF0CCAAF;
    localparam logic [27:0] D0 = 28'h556678F;

`ifdef DES_KS_PC2_EN
    localparam logic [55:0] R0_ENC  = {8'h00, 48'h1B02EFFC7072};
    localparam logic [55:0] R15_ENC = {8'h00, 48'hCB3D8B0E17F5};
`else
    localparam logic [55:0] R0_ENC  = {28'hE19955F, 28'hAACCF1E};
    localparam logic [55:0] R15_ENC = {C0, D0};
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        decrypt_i;
    logic [27:0] c0_i;
    logic [27:0] d0_i;
    logic        busy_o;
    logic        key_valid_o;
    logic        key_ready_i;
    logic [3:0]  round_o;
    logic [55:0] subkey_o;
    logic        done_o;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Cumulative left rotation after encrypt round 1..16 for schedule 16'h8103.
    int unsigned CUM [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};

    des_key_scheduler #(.HALF_W(28), .SHIFT_SCHED(16'h8103)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .decrypt_i   (decrypt_i),
        .c0_i        (c0_i),
        .d0_i        (d0_i),
        .busy_o      (busy_o),
        .key_valid_o (key_valid_o),
        .key_ready_i (key_ready_i),
        .round_o     (round_o),
        .subkey_o    (subkey_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] rotl_n(input logic [27:0] x, input int unsigned n);
        logic [27:0] y = x;
        for (int unsigned i = 0; i < n; i++) y = {y[26:0], y[27]};
        return y;
    endfunction

`ifdef DES_KS_PC2_EN
    int unsigned PC2_REF [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    function automatic logic [47:0] pc2(input logic [55:0] raw);
        logic [47:0] o = '0;
        for (int unsigned i = 0; i < 48; i++) o[6'(47 - i)] = raw[6'(56 - PC2_REF[i])];
        return o;
    endfunction
`endif

    function automatic logic [55:0] exp_key(input logic dec, input int unsigned k);
        int unsigned e = dec ? 15 - k : k;
        logic [55:0] raw = {rotl_n(C0, CUM[e]), rotl_n(D0, CUM[e])};
`ifdef DES_KS_PC2_EN
        return {8'h00, pc2(raw)};
`else
        return raw;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Requests a schedule and returns in the first valid cycle; the key inputs
    // are then scrambled so any later reload would be visible.
    task automatic do_start(input logic dec);
        start_i   = 1'b1;
        decrypt_i = dec;
        c0_i      = C0;
        d0_i      = D0;
        tick;
        start_i   = 1'b0;
        decrypt_i = ~dec;
        c0_i      = ~C0;
        d0_i      = ~D0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        n_cmp++; if (busy_o !== 1'b0)      begin n_err++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        n_cmp++; if (key_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", key_valid_o); end
        n_cmp++; if (done_o !== 1'b0)      begin n_err++; $display("FAIL reset_done got=%b want=0", done_o); end
        n_cmp++; if (round_o !== 4'd0)     begin n_err++; $display("FAIL reset_round got=%0d want=0", round_o); end
        n_cmp++; if (subkey_o !== 56'h0)   begin n_err++; $display("FAIL reset_subkey got=%h want=0", subkey_o); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_encrypt;
        key_ready_i = 1'b1;
        do_start(1'b0);
        n_cmp++; if (subkey_o !== R0_ENC) begin n_err++; $display("FAIL enc_r0_hand got=%h want=%h", subkey_o, R0_ENC); end
        for (int unsigned k = 0; k < 16; k++) begin
            n_cmp++;
            if ({key_valid_o, busy_o, done_o, round_o, subkey_o} !== {1'b1, 1'b1, 1'b0, 4'(k), exp_key(1'b0, k)}) begin
                n_err++;
                $display("FAIL enc_round%0d got v=%b b=%b d=%b r=%0d k=%h want v=1 b=1 d=0 r=%0d k=%h",
                         k, key_valid_o, busy_o, done_o, round_o, subkey_o, k, exp_key(1'b0, k));
            end
            if (k == 15) begin
                n_cmp++; if (subkey_o !== R15_ENC) begin n_err++; $display("FAIL enc_r15_hand got=%h want=%h", subkey_o, R15_ENC); end
            end
            tick;
        end
        n_cmp++;
        if ({done_o, busy_o, key_valid_o} !== 3'b100) begin
            n_err++; $display("FAIL enc_done got d/b/v=%b%b%b want 100", done_o, busy_o, key_valid_o);
        end
        tick;
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL enc_done_pulse got=%b want=0", done_o); end
    endtask

    task automatic test_decrypt;
        key_ready_i = 1'b1;
        do_start(1'b1);
        n_cmp++; if (subkey_o !== R15_ENC) begin n_err++; $display("FAIL dec_r0_hand got=%h want=%h", subkey_o, R15_ENC); end
        for (int unsigned k = 0; k < 16; k++) begin
            n_cmp++;
            if ({key_valid_o, done_o, round_o, subkey_o} !== {1'b1, 1'b0, 4'(k), exp_key(1'b1, k)}) begin
                n_err++;
                $display("FAIL dec_round%0d got v=%b d=%b r=%0d k=%h want v=1 d=0 r=%0d k=%h",
                         k, key_valid_o, done_o, round_o, subkey_o, k, exp_key(1'b1, k));
            end
            if (k == 15) begin
                n_cmp++; if (subkey_o !== R0_ENC) begin n_err++; $display("FAIL dec_r15_hand got=%h want=%h", subkey_o, R0_ENC); end
            end
            tick;
        end
        n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL dec_done got=%b want=1", done_o); end
        tick;
    endtask

    task automatic test_backpressure;
        key_ready_i = 1'b1;
        do_start(1'b0);
        for (int unsigned k = 0; k < 7; k++) begin
            n_cmp++;
            if (round_o !== 4'(k)) begin n_err++; $display("FAIL bp_pre_round got=%0d want=%0d", round_o, k); end
            tick;
        end
        key_ready_i = 1'b0;
        for (int unsigned s = 0; s < 5; s++) begin
            tick;
            n_cmp++;
            if ({key_valid_o, busy_o, round_o, subkey_o} !== {1'b1, 1'b1, 4'd7, exp_key(1'b0, 7)}) begin
                n_err++;
                $display("FAIL bp_stall%0d got v=%b b=%b r=%0d k=%h want v=1 b=1 r=7 k=%h",
                         s, key_valid_o, busy_o, round_o, subkey_o, exp_key(1'b0, 7));
            end
            // A start during the run must not reload the key or flip the mode.
            if (s == 1) begin
                start_i   = 1'b1;
                decrypt_i = 1'b1;
                c0_i      = 28'h0;
                d0_i      = 28'hFFFFFFF;
            end else begin
                start_i = 1'b0;
            end
        end
        key_ready_i = 1'b1;
        for (int unsigned k = 7; k < 16; k++) begin
            n_cmp++;
            if ({key_valid_o, round_o, subkey_o} !== {1'b1, 4'(k), exp_key(1'b0, k)}) begin
                n_err++;
                $display("FAIL bp_round%0d got v=%b r=%0d k=%h want v=1 r=%0d k=%h",
                         k, key_valid_o, round_o, subkey_o, k, exp_key(1'b0, k));
            end
            tick;
        end
        n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL bp_done got=%b want=1", done_o); end
        tick;
    endtask

    task automatic test_reset_mid_run;
        key_ready_i = 1'b1;
        do_start(1'b0);
        for (int unsigned k = 0; k < 9; k++) tick;
        n_cmp++; if (round_o !== 4'd9) begin n_err++; $display("FAIL rst_pre_round got=%0d want=9", round_o); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_cmp++;
        if ({busy_o, key_valid_o, done_o, round_o} !== 7'b0) begin
            n_err++;
            $display("FAIL rst_abort got b=%b v=%b d=%b r=%0d want all 0", busy_o, key_valid_o, done_o, round_o);
        end
        for (int unsigned s = 0; s < 3; s++) begin
            tick;
            n_cmp++;
            if ({done_o, busy_o} !== 2'b00) begin n_err++; $display("FAIL rst_no_done got d=%b b=%b want 00", done_o, busy_o); end
        end
        do_start(1'b0);
        n_cmp++;
        if ({key_valid_o, round_o, subkey_o} !== {1'b1, 4'd0, R0_ENC}) begin
            n_err++;
            $display("FAIL rst_restart got v=%b r=%0d k=%h want v=1 r=0 k=%h", key_valid_o, round_o, subkey_o, R0_ENC);
        end
        for (int unsigned k = 0; k < 16; k++) tick;
        n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL rst_restart_done got=%b want=1", done_o); end
        tick;
    endtask

    task automatic test_back_to_back;
        key_ready_i = 1'b1;
        do_start(1'b0);
        for (int unsigned k = 0; k < 16; k++) begin
            n_cmp++;
            if (round_o !== 4'(k)) begin n_err++; $display("FAIL b2b_enc_round got=%0d want=%0d", round_o, k); end
            tick;
        end
        n_cmp++;
        if ({done_o, busy_o} !== 2'b10) begin n_err++; $display("FAIL b2b_done got d=%b b=%b want 10", done_o, busy_o); end
        do_start(1'b1);
        for (int unsigned k = 0; k < 16; k++) begin
            n_cmp++;
            if ({key_valid_o, busy_o, round_o, subkey_o} !== {1'b1, 1'b1, 4'(k), exp_key(1'b1, k)}) begin
                n_err++;
                $display("FAIL b2b_dec_round%0d got v=%b b=%b r=%0d k=%h want v=1 b=1 r=%0d k=%h",
                         k, key_valid_o, busy_o, round_o, subkey_o, k, exp_key(1'b1, k));
            end
            tick;
        end
        n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL b2b_dec_done got=%b want=1", done_o); end
        tick;
    endtask

    initial begin
        rst         = 1'b1;
        start_i     = 1'b0;
        decrypt_i   = 1'b0;
        c0_i        = '0;
        d0_i        = '0;
        key_ready_i = 1'b0;
        test_reset;
        test_encrypt;
        test_decrypt;
        test_backpressure;
        test_reset_mid_run;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
